axi_tdd_ng_data_gate: RTL and testbench
=======================================

// Module: axi_tdd_ng_data_gate
// PURPOSE
//  Downstream consumer of one TDD channel output: gates a free-running ADC sample stream into DMA
//  packets, passing samples only while the (delayed) TDD gate is high and tagging the final sample
//  of each window with m_last. Sits between the ADC data path and the DMA on the TDD clock;
//  reports per-window sample counts and output overflow.
// PARAMETERS
//  DATA_WIDTH  64  sample width
//  CNT_WIDTH   16  window sample counter / max_samples width
//  GATE_DELAY  0   gate delay in clk cycles (0..15) to align gate with data pipeline; 0 = pass-through
// PORTS
//  clk           in   1           clock; everything synchronous to it
//  rst           in   1           reset, asynchronous, active-high
//  enable        in   1           gating enable
//  max_samples   in   CNT_WIDTH   per-window sample cap; 0 = unlimited; latched on window open
//  tdd_gate      in   1           TDD channel output selecting the capture window
//  s_data        in   DATA_WIDTH  input sample
//  s_valid       in   1           input sample valid (no backpressure)
//  m_data        out  DATA_WIDTH  output sample
//  m_valid       out  1           output valid
//  m_last        out  1           last sample of window
//  m_ready       in   1           downstream ready
//  overflow      out  1           sticky: a push was dropped because output was full
//  overflow_clr  in   1           clears overflow
//  win_done      out  1           1-cycle pulse at each window close
//  win_count     out  CNT_WIDTH   samples accepted in most recently closed window
//  state         out  2           FSM state: 0 IDLE, 1 WAIT, 2 PASS, 3 CLIP
// BEHAVIOUR
//  - Reset: state IDLE; m_data/m_valid/m_last/overflow/win_done/win_count = 0; pending cleared.
//    Reset mid-window discards pending data; no m_last emitted.
//  - gate_d = tdd_gate delayed by GATE_DELAY flops; rise = gate_d & ~gate_q (gate_q = gate_d reg).
//  - Accept = s_valid & gate_d & (state==PASS | (state==WAIT & rise & enable)).
//  - One-deep pending reg holds newest accepted sample. On accept with pending full:
//    push pending (last=0), then store new sample.
//  - FSM:
//    - IDLE->WAIT when enable=1.
//    - WAIT->PASS on rise (that cycle's sample accepted, max_samples latched, count reset).
//      Gate already high at enable: stay WAIT until next rise.
//    - WAIT->IDLE when enable=0.
//    - PASS close (gate_d=0 or enable=0): push pending with last=1 if pending full; pulse win_done;
//      win_count<=count; ->WAIT (->IDLE if enable=0). Sample in closing cycle is not accepted.
//    - PASS->CLIP when an accept makes count==latched max (max!=0).
//    - CLIP: first cycle pushes pending with last=1; win_done pulses and win_count<=max that cycle.
//      Further samples dropped (not overflow). ->WAIT on gate_d=0; ->IDLE if enable=0.
//  - Empty window (no accepts): close pulses win_done, win_count=0, no push.
//  - Count saturates at all-ones; never wraps.
//  - Output stage: push loads m_data/m_last, m_valid=1 next cycle; m_valid cleared when m_ready & ~push.
//    Push while m_valid & ~m_ready: push dropped, overflow set (output unchanged).
//    Simultaneous set and overflow_clr: set wins.
//  - Latency: sample appears on m_data the cycle after the next accept or window close that pushes it.
//  - At most one push per cycle; PASS close and CLIP flush never coincide with a data push.
// TESTING
//  - GATE_DELAY=0, enable=1, s_valid every cycle, gate high 8 cycles, m_ready=1
//    -> 8 beats, m_last only on 8th, win_done once, win_count=8.
//  - max_samples=3, gate high 10 cycles -> 3 beats, last on 3rd, state CLIP until gate low,
//    win_count=3, overflow=0.
//  - enable raised with gate already high -> no output until next rising edge; then full window captured.
//  - m_ready=0 for 4 cycles mid-window -> overflow=1 sticky, stale beat held;
//    overflow_clr coincident with new drop -> overflow stays 1.
//  - GATE_DELAY=5 -> window shifted 5 cycles: first accepted sample is the one 5 cycles after tdd_gate rise.
//  - rst asserted mid-window with pending full -> all outputs 0 immediately, no m_last;
//    gate high window empty of s_valid -> win_done, win_count=0, no beats.

Source files
------------

// File: rtl/axi_tdd_ng_data_gate.sv
// TDD window data gate: passes ADC samples into DMA packets while the (delayed) TDD gate is open,
// marks the final sample of each window with m_last, and reports per-window counts and overflow.
module axi_tdd_ng_data_gate #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 16,
    parameter int GATE_DELAY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [CNT_WIDTH-1:0]  max_samples,
    input  logic                  tdd_gate,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  overflow,
    input  logic                  overflow_clr,
    output logic                  win_done,
    output logic [CNT_WIDTH-1:0]  win_count,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        PASS = 2'd2,
        CLIP = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    state_t                  state_r, state_nxt_s;
    logic                    gate_d_s, gate_q_r, rise_s, accept_s;
    logic                    pend_valid_r, pend_valid_nxt_s;
    logic [DATA_WIDTH-1:0]   pend_data_r, pend_data_nxt_s;
    logic [CNT_WIDTH-1:0]    count_r, count_nxt_s, count_inc_s;
    logic [CNT_WIDTH-1:0]    max_r, max_nxt_s, done_count_s;
    logic                    push_s, push_last_s, done_s, drop_s;

    generate
        if (GATE_DELAY == 0) begin : g_no_delay
            assign gate_d_s = tdd_gate;
        end else begin : g_delay
            logic [GATE_DELAY-1:0] dly_r;
            // Gate delay line aligning the window with the data pipeline.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dly_r <= {GATE_DELAY{1'b0}};
                end else begin
                    dly_r[0] <= tdd_gate;
                    for (int i = 1; i < GATE_DELAY; i++) begin
                        dly_r[i] <= dly_r[i-1];
                    end
                end
            end
            assign gate_d_s = dly_r[GATE_DELAY-1];
        end
    endgenerate

    assign rise_s      = gate_d_s & ~gate_q_r;
    assign accept_s    = s_valid & gate_d_s & enable &
                         ((state_r == PASS) | ((state_r == WAIT) & rise_s));
    assign count_inc_s = (count_r == CNT_MAX) ? count_r : count_r + CNT_ONE;
    assign state       = state_r;

    // Window FSM, pending sample register and push requests.
    always_comb begin
        state_nxt_s      = state_r;
        pend_valid_nxt_s = pend_valid_r;
        pend_data_nxt_s  = pend_data_r;
        count_nxt_s      = count_r;
        max_nxt_s        = max_r;
        push_s           = 1'b0;
        push_last_s      = 1'b0;
        done_s           = 1'b0;
        done_count_s     = count_r;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (!enable) begin
                    state_nxt_s = IDLE;
                end else if (rise_s) begin
                    state_nxt_s = PASS;
                    max_nxt_s   = max_samples;
                    count_nxt_s = CNT_ZERO;
                    if (accept_s) begin
                        pend_valid_nxt_s = 1'b1;
                        pend_data_nxt_s  = s_data;
                        count_nxt_s      = CNT_ONE;
                        if (max_samples == CNT_ONE) begin
                            state_nxt_s = CLIP;
                        end else begin
                            state_nxt_s = PASS;
                        end
                    end else begin
                        pend_valid_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            PASS: begin
                if (!gate_d_s || !enable) begin
                    push_s           = pend_valid_r;
                    push_last_s      = 1'b1;
                    pend_valid_nxt_s = 1'b0;
                    done_s           = 1'b1;
                    state_nxt_s      = enable ? WAIT : IDLE;
                end else if (accept_s) begin
                    push_s           = pend_valid_r;
                    pend_valid_nxt_s = 1'b1;
                    pend_data_nxt_s  = s_data;
                    count_nxt_s      = count_inc_s;
                    if ((max_r != CNT_ZERO) && (count_inc_s == max_r)) begin
                        state_nxt_s = CLIP;
                    end else begin
                        state_nxt_s = PASS;
                    end
                end else begin
                    state_nxt_s = PASS;
                end
            end
            CLIP: begin
                // Pending is only full on the first CLIP cycle: it holds the capped sample.
                if (pend_valid_r) begin
                    push_s           = 1'b1;
                    push_last_s      = 1'b1;
                    pend_valid_nxt_s = 1'b0;
                    done_s           = 1'b1;
                    done_count_s     = max_r;
                end else begin
                    push_s = 1'b0;
                end
                if (!enable) begin
                    state_nxt_s = IDLE;
                end else if (!gate_d_s) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = CLIP;
                end
            end
            default: begin
                state_nxt_s      = IDLE;
                pend_valid_nxt_s = 1'b0;
            end
        endcase
    end

    assign drop_s = push_s & m_valid & ~m_ready;

    // Control and pending-sample state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            gate_q_r     <= 1'b0;
            pend_valid_r <= 1'b0;
            pend_data_r  <= {DATA_WIDTH{1'b0}};
            count_r      <= CNT_ZERO;
            max_r        <= CNT_ZERO;
        end else begin
            state_r      <= state_nxt_s;
            gate_q_r     <= gate_d_s;
            pend_valid_r <= pend_valid_nxt_s;
            pend_data_r  <= pend_data_nxt_s;
            count_r      <= count_nxt_s;
            max_r        <= max_nxt_s;
        end
    end

    // Output beat register, sticky overflow and window statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data    <= {DATA_WIDTH{1'b0}};
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            overflow  <= 1'b0;
            win_done  <= 1'b0;
            win_count <= CNT_ZERO;
        end else begin
            if (push_s && !drop_s) begin
                m_data  <= pend_data_r;
                m_last  <= push_last_s;
                m_valid <= 1'b1;
            end else if (m_ready && !push_s) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
            overflow <= drop_s | (overflow & ~overflow_clr);
            win_done <= done_s;
            if (done_s) begin
                win_count <= done_count_s;
            end
        end
    end

endmodule

// File: tb/tb_axi_tdd_ng_data_gate.sv
// Directed self-checking bench for axi_tdd_ng_data_gate; a second instance uses GATE_DELAY=5.
module tb_axi_tdd_ng_data_gate;
    localparam int DW = 64;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst, enable, tdd_gate, s_valid, m_ready, overflow_clr;
    logic [CW-1:0] max_samples;
    logic [DW-1:0] s_data;

    logic [DW-1:0] a_m_data, b_m_data;
    logic          a_m_valid, a_m_last, a_overflow, a_win_done;
    logic          b_m_valid, b_m_last, b_overflow, b_win_done;
    logic [CW-1:0] a_win_count, b_win_count;
    logic [1:0]    a_state, b_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] a_data_q[$], b_data_q[$];
    logic          a_last_q[$], b_last_q[$];
    int            a_done_cnt, b_done_cnt;

    axi_tdd_ng_data_gate #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .GATE_DELAY(0)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .max_samples(max_samples), .tdd_gate(tdd_gate),
        .s_data(s_data), .s_valid(s_valid), .m_data(a_m_data), .m_valid(a_m_valid),
        .m_last(a_m_last), .m_ready(m_ready), .overflow(a_overflow), .overflow_clr(overflow_clr),
        .win_done(a_win_done), .win_count(a_win_count), .state(a_state)
    );

    axi_tdd_ng_data_gate #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .GATE_DELAY(5)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .max_samples(max_samples), .tdd_gate(tdd_gate),
        .s_data(s_data), .s_valid(s_valid), .m_data(b_m_data), .m_valid(b_m_valid),
        .m_last(b_m_last), .m_ready(m_ready), .overflow(b_overflow), .overflow_clr(overflow_clr),
        .win_done(b_win_done), .win_count(b_win_count), .state(b_state)
    );

    always #5 clk = ~clk;

    // Beat and window-close monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_m_valid && m_ready) begin
                a_data_q.push_back(a_m_data);
                a_last_q.push_back(a_m_last);
            end
            if (b_m_valid && m_ready) begin
                b_data_q.push_back(b_m_data);
                b_last_q.push_back(b_m_last);
            end
            if (a_win_done) a_done_cnt++;
            if (b_win_done) b_done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        a_data_q.delete(); a_last_q.delete(); b_data_q.delete(); b_last_q.delete();
        a_done_cnt = 0; b_done_cnt = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; enable = 1'b0; tdd_gate = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        overflow_clr = 1'b0; max_samples = 16'd0; s_data = 64'd0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        clear_mon();
    endtask

    task automatic run_window(input logic [DW-1:0] base, input int n_high, input int n_low,
                              input logic sv);
        for (int i = 0; i < n_high; i++) begin
            tdd_gate = 1'b1; s_valid = sv; s_data = base + 64'(i);
            tick();
        end
        for (int i = 0; i < n_low; i++) begin
            tdd_gate = 1'b0; s_valid = sv; s_data = 64'hDEAD_0000 + 64'(i);
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; tdd_gate = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        overflow_clr = 1'b0; max_samples = 16'd0; s_data = 64'd0;
        tick();
        n_tests++;
        if ({a_m_valid, a_m_last, a_overflow, a_win_done} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {a_m_valid, a_m_last, a_overflow, a_win_done});
        end
        n_tests++;
        if (a_m_data !== 64'd0 || a_win_count !== 16'd0 || a_state !== 2'd0) begin
            n_fail++; $display("FAIL reset_regs: data %h count %0d state %0d want 0", a_m_data, a_win_count, a_state);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_window();
        apply_reset();
        enable = 1'b1;
        repeat (2) tick();
        run_window(64'h1000, 8, 4, 1'b1);
        n_tests++;
        if (a_data_q.size() !== 8) begin
            n_fail++; $display("FAIL basic_beats: got %0d want 8", a_data_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (a_data_q[i] !== 64'h1000 + 64'(i) || a_last_q[i] !== (i == 7)) begin
                    n_fail++; $display("FAIL basic_beat%0d: got %h/%b want %h/%b", i, a_data_q[i], a_last_q[i], 64'h1000 + 64'(i), (i == 7));
                end
            end
        end
        n_tests++;
        if (a_done_cnt !== 1 || a_win_count !== 16'd8) begin
            n_fail++; $display("FAIL basic_win: done %0d count %0d want 1/8", a_done_cnt, a_win_count);
        end
        n_tests++;
        if (a_state !== 2'd1) begin
            n_fail++; $display("FAIL basic_state: got %0d want 1", a_state);
        end
    endtask

    task automatic test_clip();
        apply_reset();
        enable = 1'b1; max_samples = 16'd3;
        repeat (2) tick();
        for (int i = 0; i < 10; i++) begin
            tdd_gate = 1'b1; s_valid = 1'b1; s_data = 64'h2000 + 64'(i);
            tick();
            if (i == 6) begin
                n_tests++;
                if (a_state !== 2'd3) begin
                    n_fail++; $display("FAIL clip_state: got %0d want 3", a_state);
                end
            end
        end
        tdd_gate = 1'b0;
        tick();
        n_tests++;
        if (a_state !== 2'd1) begin
            n_fail++; $display("FAIL clip_exit: got %0d want 1", a_state);
        end
        repeat (3) tick();
        n_tests++;
        if (a_data_q.size() !== 3) begin
            n_fail++; $display("FAIL clip_beats: got %0d want 3", a_data_q.size());
        end else begin
            n_tests++;
            if (a_data_q[0] !== 64'h2000 || a_data_q[2] !== 64'h2002 || a_last_q[1] !== 1'b0 || a_last_q[2] !== 1'b1) begin
                n_fail++; $display("FAIL clip_data: got %h %h last %b%b want 2000 2002 last 01", a_data_q[0], a_data_q[2], a_last_q[1], a_last_q[2]);
            end
        end
        n_tests++;
        if (a_done_cnt !== 1 || a_win_count !== 16'd3 || a_overflow !== 1'b0) begin
            n_fail++; $display("FAIL clip_win: done %0d count %0d ovf %b want 1/3/0", a_done_cnt, a_win_count, a_overflow);
        end
    endtask

    task automatic test_gate_already_high();
        apply_reset();
        tdd_gate = 1'b1; s_valid = 1'b1; s_data = 64'h3333;
        repeat (3) tick();
        enable = 1'b1;
        repeat (5) tick();
        n_tests++;
        if (a_data_q.size() !== 0 || a_done_cnt !== 0 || a_state !== 2'd1) begin
            n_fail++; $display("FAIL early_gate: beats %0d done %0d state %0d want 0/0/1", a_data_q.size(), a_done_cnt, a_state);
        end
        tdd_gate = 1'b0;
        repeat (2) tick();
        run_window(64'h3000, 4, 4, 1'b1);
        n_tests++;
        if (a_data_q.size() !== 4 || a_win_count !== 16'd4) begin
            n_fail++; $display("FAIL late_window: beats %0d count %0d want 4/4", a_data_q.size(), a_win_count);
        end else begin
            n_tests++;
            if (a_data_q[0] !== 64'h3000 || a_data_q[3] !== 64'h3003 || a_last_q[3] !== 1'b1) begin
                n_fail++; $display("FAIL late_data: got %h %h last %b want 3000 3003 1", a_data_q[0], a_data_q[3], a_last_q[3]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp_q[$];
        apply_reset();
        enable = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 14; i++) begin
            tdd_gate = (i < 10); s_valid = 1'b1; s_data = 64'h4000 + 64'(i);
            m_ready = !(i >= 3 && i <= 6);
            tick();
            if (i == 5) begin
                n_tests++;
                if (a_m_data !== 64'h4001 || a_m_valid !== 1'b1) begin
                    n_fail++; $display("FAIL stall_hold: got %h/%b want 4001/1", a_m_data, a_m_valid);
                end
            end
        end
        exp_q = '{64'h4000, 64'h4001, 64'h4006, 64'h4007, 64'h4008, 64'h4009};
        n_tests++;
        if (a_data_q.size() !== 6) begin
            n_fail++; $display("FAIL ovf_beats: got %0d want 6", a_data_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_tests++;
                if (a_data_q[i] !== exp_q[i] || a_last_q[i] !== (i == 5)) begin
                    n_fail++; $display("FAIL ovf_beat%0d: got %h/%b want %h/%b", i, a_data_q[i], a_last_q[i], exp_q[i], (i == 5));
                end
            end
        end
        n_tests++;
        if (a_overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky: got %b want 1", a_overflow);
        end
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        n_tests++;
        if (a_overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear: got %b want 0", a_overflow);
        end
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tdd_gate = 1'b1; s_valid = 1'b1; s_data = 64'h4100 + 64'(i);
            overflow_clr = (i == 2);
            tick();
            if (i == 2) begin
                n_tests++;
                if (a_overflow !== 1'b1) begin
                    n_fail++; $display("FAIL ovf_set_wins: got %b want 1", a_overflow);
                end
            end
        end
        overflow_clr = 1'b0; m_ready = 1'b1;
        run_window(64'h0, 0, 4, 1'b1);
        n_tests++;
        if (a_overflow !== 1'b1 || a_m_valid !== 1'b0) begin
            n_fail++; $display("FAIL ovf_end: ovf %b valid %b want 1/0", a_overflow, a_m_valid);
        end
    endtask

    task automatic test_gate_delay();
        apply_reset();
        enable = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 15; i++) begin
            tdd_gate = (i < 4); s_valid = 1'b1; s_data = 64'h5000 + 64'(i);
            tick();
        end
        n_tests++;
        if (b_data_q.size() !== 4) begin
            n_fail++; $display("FAIL dly_beats: got %0d want 4", b_data_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (b_data_q[i] !== 64'h5005 + 64'(i) || b_last_q[i] !== (i == 3)) begin
                    n_fail++; $display("FAIL dly_beat%0d: got %h/%b want %h/%b", i, b_data_q[i], b_last_q[i], 64'h5005 + 64'(i), (i == 3));
                end
            end
        end
        n_tests++;
        if (b_done_cnt !== 1 || b_win_count !== 16'd4) begin
            n_fail++; $display("FAIL dly_win: done %0d count %0d want 1/4", b_done_cnt, b_win_count);
        end
    endtask

    task automatic test_reset_midwindow();
        apply_reset();
        enable = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            tdd_gate = 1'b1; s_valid = 1'b1; s_data = 64'h6000 + 64'(i);
            tick();
        end
        rst = 1'b1; tdd_gate = 1'b0;
        clear_mon();
        #1;
        n_tests++;
        if ({a_m_valid, a_m_last, a_win_done, a_overflow} !== 4'b0000 || a_m_data !== 64'd0 || a_state !== 2'd0) begin
            n_fail++; $display("FAIL rst_mid: flags %b data %h state %0d want 0", {a_m_valid, a_m_last, a_win_done, a_overflow}, a_m_data, a_state);
        end
        tick();
        rst = 1'b0;
        repeat (4) tick();
        n_tests++;
        if (a_data_q.size() !== 0 || a_done_cnt !== 0) begin
            n_fail++; $display("FAIL rst_flush: beats %0d done %0d want 0/0", a_data_q.size(), a_done_cnt);
        end
        run_window(64'h6100, 2, 3, 1'b1);
        n_tests++;
        if (a_win_count !== 16'd2 || a_done_cnt !== 1) begin
            n_fail++; $display("FAIL short_win: count %0d done %0d want 2/1", a_win_count, a_done_cnt);
        end
        run_window(64'h6200, 5, 3, 1'b0);
        n_tests++;
        if (a_win_count !== 16'd0 || a_done_cnt !== 2 || a_data_q.size() !== 2) begin
            n_fail++; $display("FAIL empty_win: count %0d done %0d beats %0d want 0/2/2", a_win_count, a_done_cnt, a_data_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_window();
        test_clip();
        test_gate_already_high();
        test_overflow();
        test_gate_delay();
        test_reset_midwindow();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
